// File: rtl/alu_op_decoder.sv
// RV32I ALU-class decode stage: one registered stage with valid/ready handshake,
// producing the one-hot ALU select, register indices, immediate and operand-select flags.
module alu_op_decoder #(
    parameter int XLEN = 32,
    parameter int OPW  = 11
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OPW-1:0]  alu_op,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic            rd_we,
    output logic [XLEN-1:0] imm,
    output logic            src1_is_pc,
    output logic            src2_is_imm,
    output logic [XLEN-1:0] pc_out,
    output logic            illegal
);

    localparam logic [OPW-1:0] A_ADD  = OPW'(1) << 0;
    localparam logic [OPW-1:0] A_SUB  = OPW'(1) << 1;
    localparam logic [OPW-1:0] A_SLT  = OPW'(1) << 2;
    localparam logic [OPW-1:0] A_SLTU = OPW'(1) << 3;
    localparam logic [OPW-1:0] A_AND  = OPW'(1) << 4;
    localparam logic [OPW-1:0] A_OR   = OPW'(1) << 5;
    localparam logic [OPW-1:0] A_XOR  = OPW'(1) << 6;
    localparam logic [OPW-1:0] A_SLL  = OPW'(1) << 7;
    localparam logic [OPW-1:0] A_SRL  = OPW'(1) << 8;
    localparam logic [OPW-1:0] A_SRA  = OPW'(1) << 9;
    localparam logic [OPW-1:0] A_LUI  = OPW'(1) << 10;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] F7_ZERO   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    typedef struct packed {
        logic [OPW-1:0]  op;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            we;
        logic [XLEN-1:0] imm;
        logic            s1pc;
        logic            s2imm;
        logic            ill;
        logic [XLEN-1:0] pc;
    } dec_t;

    function automatic logic [OPW-1:0] f3_op(input logic [2:0] f3);
        case (f3)
            3'b000:  f3_op = A_ADD;
            3'b001:  f3_op = A_SLL;
            3'b010:  f3_op = A_SLT;
            3'b011:  f3_op = A_SLTU;
            3'b100:  f3_op = A_XOR;
            3'b101:  f3_op = A_SRL;
            3'b110:  f3_op = A_OR;
            default: f3_op = A_AND;
        endcase
    endfunction

    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic       accept;
    logic       vld_q;
    dec_t       d, q;

    assign opc = in_inst[6:0];
    assign f3  = in_inst[14:12];
    assign f7  = in_inst[31:25];

    always_comb begin
        d       = '0;
        d.rs1   = in_inst[19:15];
        d.rs2   = in_inst[24:20];
        d.pc    = in_pc;
        case (opc)
            OPC_OP: begin
                d.op = f3_op(f3);
                d.we = 1'b1;
                if (f7 == F7_ALT && f3 == 3'b000)      d.op  = A_SUB;
                else if (f7 == F7_ALT && f3 == 3'b101) d.op  = A_SRA;
                else if (f7 != F7_ZERO)                d.ill = 1'b1;
            end
            OPC_OPIMM: begin
                d.op    = f3_op(f3);
                d.we    = 1'b1;
                d.s2imm = 1'b1;
                d.imm   = {{20{in_inst[31]}}, in_inst[31:20]};
                // Shift immediates carry funct7 in imm[11:5]; only shamt feeds the ALU.
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    d.imm = {27'b0, in_inst[24:20]};
                    if (f3 == 3'b101 && f7 == F7_ALT) d.op  = A_SRA;
                    else if (f7 != F7_ZERO)           d.ill = 1'b1;
                end
            end
            OPC_LUI: begin
                d.op    = A_LUI;
                d.we    = 1'b1;
                d.s2imm = 1'b1;
                d.imm   = {in_inst[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                d.op    = A_ADD;
                d.we    = 1'b1;
                d.s1pc  = 1'b1;
                d.s2imm = 1'b1;
                d.imm   = {in_inst[31:12], 12'b0};
            end
            OPC_LOAD: begin
                d.op    = A_ADD;
                d.we    = 1'b1;
                d.s2imm = 1'b1;
                d.imm   = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            OPC_STORE: begin
                d.op    = A_ADD;
                d.s2imm = 1'b1;
                d.imm   = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            end
            default: d.ill = 1'b1;
        endcase
        // Illegal bundles still flow so execute can trap, but must not act.
        if (d.ill) begin
            d.op    = '0;
            d.we    = 1'b0;
            d.imm   = '0;
            d.s1pc  = 1'b0;
            d.s2imm = 1'b0;
        end
        if (in_inst[11:7] == 5'd0) d.we = 1'b0;
        d.rd = d.we ? in_inst[11:7] : 5'd0;
    end

    assign in_ready = ~vld_q | out_ready;
    assign accept   = in_valid & in_ready & ~flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= 1'b0;
            q     <= '0;
        end else begin
            if (flush)          vld_q <= 1'b0;
            else if (accept)    vld_q <= 1'b1;
            else if (out_ready) vld_q <= 1'b0;
            if (accept) q <= d;
        end
    end

    assign out_valid   = vld_q;
    assign alu_op      = q.op;
    assign rs1         = q.rs1;
    assign rs2         = q.rs2;
    assign rd          = q.rd;
    assign rd_we       = q.we;
    assign imm         = q.imm;
    assign src1_is_pc  = q.s1pc;
    assign src2_is_imm = q.s2imm;
    assign pc_out      = q.pc;
    assign illegal     = q.ill;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Directed bench for alu_op_decoder: hand-decoded RV32I words, backpressure, flush and async reset.
module tb_alu_op_decoder;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_inst, in_pc, imm, pc_out;
    logic [10:0] alu_op;
    logic [4:0]  rs1, rs2, rd;
    logic        rd_we, src1_is_pc, src2_is_imm, illegal;

    int n_cmp = 0;
    int n_err = 0;

    alu_op_decoder dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op),
        .rs1(rs1), .rs2(rs2), .rd(rd), .rd_we(rd_we), .imm(imm),
        .src1_is_pc(src1_is_pc), .src2_is_imm(src2_is_imm),
        .pc_out(pc_out), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one instruction; returns at the negedge after the capturing edge.
    task automatic issue(input logic [31:0] i, input logic [31:0] p);
        in_valid = 1'b1;
        in_inst  = i;
        in_pc    = p;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_op", alu_op, 0);
        chk("rst_imm", imm, 0);
        chk("rst_pc", pc_out, 0);
        chk("rst_rdy", in_ready, 1);
        reset = 1'b0;

        // add x3,x1,x2
        issue(32'h002081B3, 32'h100);
        chk("add_valid", out_valid, 1);
        chk("add_op", alu_op, 11'b000_0000_0001);
        chk("add_rs1", rs1, 1);
        chk("add_rs2", rs2, 2);
        chk("add_rd", rd, 3);
        chk("add_we", rd_we, 1);
        chk("add_s2imm", src2_is_imm, 0);
        chk("add_pc", pc_out, 32'h100);
        chk("add_ill", illegal, 0);
        issue(32'h402081B3, 32'h104);
        chk("sub_op", alu_op, 11'b000_0000_0010);

        // srai x5,x6,4
        issue(32'h40435293, 32'h108);
        chk("srai_op", alu_op, 11'b010_0000_0000);
        chk("srai_imm", imm, 32'h4);
        chk("srai_s2imm", src2_is_imm, 1);
        chk("srai_rd", rd, 5);
        chk("srai_rs1", rs1, 6);
        // lui x1,0x80000
        issue(32'h800000B7, 32'h10C);
        chk("lui_op", alu_op, 11'b100_0000_0000);
        chk("lui_imm", imm, 32'h80000000);
        chk("lui_we", rd_we, 1);
        // addi x1,x0,-1: sign extension
        issue(32'hFFF00093, 32'h110);
        chk("addi_op", alu_op, 11'b000_0000_0001);
        chk("addi_imm", imm, 32'hFFFFFFFF);
        // nop: rd=x0 suppresses the write
        issue(32'h00000013, 32'h114);
        chk("nop_op", alu_op, 11'b000_0000_0001);
        chk("nop_we", rd_we, 0);
        chk("nop_rd", rd, 0);
        // auipc x2,1
        issue(32'h00001117, 32'h118);
        chk("auipc_op", alu_op, 11'b000_0000_0001);
        chk("auipc_imm", imm, 32'h1000);
        chk("auipc_s1pc", src1_is_pc, 1);
        chk("auipc_rd", rd, 2);
        // sw x1,4(x2)
        issue(32'h00112223, 32'h11C);
        chk("sw_op", alu_op, 11'b000_0000_0001);
        chk("sw_imm", imm, 32'h4);
        chk("sw_we", rd_we, 0);
        chk("sw_rd", rd, 0);
        chk("sw_s2imm", src2_is_imm, 1);
        // lw x1,-4(x2)
        issue(32'hFFC12083, 32'h120);
        chk("lw_imm", imm, 32'hFFFFFFFC);
        chk("lw_we", rd_we, 1);
        chk("lw_rd", rd, 1);

        // jal: illegal but still flows
        issue(32'h0000006F, 32'h124);
        chk("jal_valid", out_valid, 1);
        chk("jal_ill", illegal, 1);
        chk("jal_op", alu_op, 0);
        chk("jal_we", rd_we, 0);
        issue(32'h602081B3, 32'h128);
        chk("badf7_ill", illegal, 1);
        chk("badf7_op", alu_op, 0);
        issue(32'h002081B0, 32'h12C);
        chk("badlo_ill", illegal, 1);

        // Backpressure: freeze for 3 cycles, then drain a 4-instruction stream
        in_valid = 1'b0;
        @(negedge clk);
        chk("idle_valid", out_valid, 0);
        out_ready = 1'b0;
        issue(32'h002081B3, 32'h200);
        chk("bp_valid", out_valid, 1);
        in_inst = 32'h402081B3; in_pc = 32'h204;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_rdy", in_ready, 0);
            chk("bp_pc", pc_out, 32'h200);
            chk("bp_op", alu_op, 11'b000_0000_0001);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("st_pc1", pc_out, 32'h204);
        chk("st_op1", alu_op, 11'b000_0000_0010);
        issue(32'h0020C1B3, 32'h208);
        chk("st_pc2", pc_out, 32'h208);
        chk("st_op2", alu_op, 11'b000_0100_0000);
        issue(32'h0020F1B3, 32'h20C);
        chk("st_pc3", pc_out, 32'h20C);
        chk("st_op3", alu_op, 11'b000_0001_0000);
        in_valid = 1'b0;
        @(negedge clk);
        chk("st_drain", out_valid, 0);

        // flush with a valid instruction present and a bundle in the stage
        issue(32'h002081B3, 32'h300);
        flush = 1'b1;
        issue(32'h0020C1B3, 32'h304);
        flush = 1'b0;
        chk("fl_valid", out_valid, 0);
        issue(32'h402081B3, 32'h308);
        chk("fl_next_valid", out_valid, 1);
        chk("fl_next_op", alu_op, 11'b000_0000_0010);
        chk("fl_next_pc", pc_out, 32'h308);

        // async reset while a bundle is held
        out_ready = 1'b0;
        issue(32'h002081B3, 32'h400);
        chk("ar_pre", out_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_op", alu_op, 0);
        chk("ar_rd", rd, 0);
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("ar_rdy", in_ready, 1);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
